// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO.
// Ports: clk, rst, start, op, a, b, hi_we, lo_we, wd -> busy, done, hi, lo.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               bz_q, bz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_step, div_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    sa    = op[0] & a[WIDTH-1];
    sb    = op[0] & b[WIDTH-1];
    abs_a = sa ? -a : a;
    abs_b = sb ? -b : b;

    // acc = {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + {1'b0, (acc_q[0] ? m_q : '0)};
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // acc = {partial remainder, dividend shifting into quotient}
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, m_q};
    div_diff = div_sh - {1'b0, m_q};
    div_step = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                acc_q[WIDTH-2:0], div_ge};

    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    bz_d      = bz_q;
    acc_d     = acc_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_d     = sa ^ sb;
          neg_rem_d = sa;
          bz_d      = (b == '0);
          acc_d     = op[1] ? {{WIDTH{1'b0}}, abs_a}
                            : {{WIDTH{1'b0}}, abs_b};
          m_d       = op[1] ? abs_b : abs_a;
        end else begin
          if (hi_we) hi_d = wd;
          if (lo_we) lo_d = wd;
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIN;
      end
      FIN: begin
        if (is_div_q) begin
          // divide-by-zero keeps the all-ones quotient unsigned
          lo_d = (neg_q && !bz_q) ? -quo : quo;
          hi_d = neg_rem_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      bz_q      <= 1'b0;
      acc_q     <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      bz_q      <= bz_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed scoreboard bench for mdu_iter.
// Expected {hi,lo} pushed at launch, popped on done.
module tb_mdu_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wd;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wd   (wd),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting edge.
  task automatic launch(logic [1:0] o, logic [W-1:0] x,
                        logic [W-1:0] y, logic [63:0] exp);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic finish_op(string tag, int exp_busy);
    int nb = 0;
    bit got = 1'b0;
    logic [63:0] e;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (busy) nb++;
    end
    check({tag, "_done"}, 64'(got), 64'd1);
    check({tag, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    e = 'x;
    if (sb_q.size() != 0) e = sb_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, e);
  endtask

  initial begin
    int ndone;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wd    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);

    // 1: MULTU max*max
    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    finish_op("multu_max", 33);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);

    // 2: MULT -3*7
    launch(2'b01, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
    finish_op("mult_neg", 33);

    // 3: DIVU then DIV back-to-back (start in done cycle)
    @(negedge clk);
    launch(2'b10, 32'd100, 32'd7, {32'd2, 32'd14});
    finish_op("divu_100_7", 33);
    launch(2'b11, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    finish_op("div_m7_2", 33);

    // 4: divide by zero and overflow case
    launch(2'b10, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
    finish_op("divu_by0", 33);
    launch(2'b11, 32'hFFFFFFF0, 32'd0, {32'hFFFFFFF0, 32'hFFFFFFFF});
    finish_op("div_neg_by0", 33);
    launch(2'b11, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
    finish_op("div_ovf", 33);

    // 5: start and MTHI ignored while busy; hi/lo stable in CALC
    launch(2'b00, 32'd3, 32'd4, {32'd0, 32'd12});
    repeat (4) @(negedge clk);
    check("stable_calc", {hi, lo}, {32'd0, 32'h80000000});
    start = 1'b1;
    op    = 2'b10;
    a     = 32'd9;
    b     = 32'd9;
    hi_we = 1'b1;
    wd    = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    finish_op("busy_ignore", 28);
    hi_we = 1'b1;
    wd    = 32'hBEEF;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", {hi, lo}, {32'hBEEF, 32'd12});
    check("no_relaunch", 64'(busy), 64'd0);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wd    = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'h1234, 32'h1234});

    // 6: reset mid-operation
    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    sb_q.delete();
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    hi_we = 1'b1;
    wd    = 32'hFFFF;
    launch(2'b00, 32'd6, 32'd7, {32'd0, 32'd42});
    @(negedge clk);
    check("start_wins", 64'(hi), 64'd0);
    finish_op("multu_6_7", 32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
